// File: rtl/islip_grant_arbiter.sv
// islip_grant_arbiter: grant stage of a flattened-priority iSLIP scheduler,
// one instance per output port. A request snapshot is captured, the highest
// non-empty priority level is chosen, and one requester in that level gets a
// round-robin grant from that level's pointer. The pointer advances only when
// the grant is accepted, so a rejected requester keeps its turn.
module islip_grant_arbiter #(
  parameter int N = 24,
  parameter int P = 8,
  localparam int LW = (P > 1) ? $clog2(P) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [N*P-1:0]  i_request,
  input  logic            i_accept,
  input  logic            i_reject,
  output logic            o_grant_valid,
  output logic [N-1:0]    o_grant,
  output logic [LW-1:0]   o_grant_level,
  output logic            o_empty,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N*P-1:0]   req_q, req_d;
  logic [NW-1:0]    ptr_q [P];
  logic [NW-1:0]    ptr_d [P];
  logic [N-1:0]     grant_q, grant_d;
  logic [LW-1:0]    level_q, level_d;
  logic [NW-1:0]    idx_q, idx_d;
  logic             gvalid_q, gvalid_d;
  logic             empty_q, empty_d;
  logic             busy_q, busy_d;

  logic             sel_any;
  logic [LW-1:0]    sel_level;
  logic [N-1:0]     lvl_req;
  logic [NW-1:0]    lvl_ptr;
  logic             hi_found;
  logic [NW-1:0]    hi_idx;
  logic [NW-1:0]    lo_idx;
  logic [NW-1:0]    sel_idx;

  // Pick the highest non-empty level, then the first requester at or after
  // that level's pointer, falling back to the lowest requester on wrap.
  always_comb begin
    sel_any   = 1'b0;
    sel_level = '0;
    for (int j = 0; j < P; j++) begin
      if (|req_q[j*N +: N]) begin
        sel_any   = 1'b1;
        sel_level = LW'(j);
      end
    end
    lvl_req  = req_q[sel_level*N +: N];
    lvl_ptr  = ptr_q[sel_level];
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (lvl_req[i]) begin
        lo_idx = NW'(i);
        if (i >= int'(lvl_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = NW'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  // Next-state and next-output logic for the IDLE/EVAL/GRANT sequence.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    level_d  = level_q;
    idx_d    = idx_q;
    gvalid_d = gvalid_q;
    empty_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          req_d   = i_request;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (!sel_any) begin
          empty_d = 1'b1;
          state_d = IDLE;
        end else begin
          grant_d  = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          level_d  = sel_level;
          idx_d    = sel_idx;
          gvalid_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (i_accept) begin
          ptr_d[level_q] = (idx_q == NW'(N - 1)) ? '0 : idx_q + NW'(1);
        end
        if (i_accept || i_reject) begin
          grant_d  = '0;
          level_d  = '0;
          gvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        level_d  = '0;
        gvalid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointers and registered outputs; reset drops any pending grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      for (int j = 0; j < P; j++) begin
        ptr_q[j] <= '0;
      end
      grant_q  <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      gvalid_q <= 1'b0;
      empty_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      gvalid_q <= gvalid_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
    end
  end

  assign o_grant_valid = gvalid_q;
  assign o_grant       = grant_q;
  assign o_grant_level = level_q;
  assign o_empty       = empty_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_islip_grant_arbiter.sv
// Testbench for islip_grant_arbiter with N=4, P=2: directed scenarios followed
// by randomized decisions, all checked against a rotation-based reference.
module tb_islip_grant_arbiter;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int LW = 1;

  logic            clk;
  logic            rst_n;
  logic            i_valid;
  logic [N*P-1:0]  i_request;
  logic            i_accept;
  logic            i_reject;
  logic            o_grant_valid;
  logic [N-1:0]    o_grant;
  logic [LW-1:0]   o_grant_level;
  logic            o_empty;
  logic            o_busy;

  int checks;
  int errors;
  int mptr [P];

  islip_grant_arbiter #(.N(N), .P(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .i_request     (i_request),
    .i_accept      (i_accept),
    .i_reject      (i_reject),
    .o_grant_valid (o_grant_valid),
    .o_grant       (o_grant),
    .o_grant_level (o_grant_level),
    .o_empty       (o_empty),
    .o_busy        (o_busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: highest non-empty level, then rotate from that level's pointer
  function automatic void modelPick(input logic [N*P-1:0] req, output bit empty,
                                    output int lvl, output int k);
    empty = 1'b1;
    lvl   = 0;
    k     = 0;
    for (int j = P - 1; j >= 0; j--) begin
      if (req[j*N +: N] != '0) begin
        empty = 1'b0;
        lvl   = j;
        break;
      end
    end
    if (!empty) begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (mptr[lvl] + off) % N;
        if (req[lvl*N + idx]) begin
          k = idx;
          break;
        end
      end
    end
  endfunction

  // Check that every output is at its reset value
  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gvalid"}, 32'(o_grant_valid), 32'd0);
    checkOutput({tag, "_grant"},  32'(o_grant),       32'd0);
    checkOutput({tag, "_level"},  32'(o_grant_level), 32'd0);
    checkOutput({tag, "_empty"},  32'(o_empty),       32'd0);
    checkOutput({tag, "_busy"},   32'(o_busy),        32'd0);
  endtask

  // Pulse reset from a falling edge and check outputs clear asynchronously
  task automatic applyReset();
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_accept  = 1'b0;
    i_reject  = 1'b0;
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < P; j++) mptr[j] = 0;
  endtask

  // One full decision. action: 0 accept, 1 reject, 2 accept+reject, 3 reset
  // mid-grant. knownGrant, when nonzero, is the grant value expected directly.
  task automatic applyStimulus(input logic [N*P-1:0] req, input int action,
                               input int hold, input bit poke,
                               input logic [N-1:0] knownGrant);
    bit exp_empty;
    int exp_lvl;
    int exp_k;
    int cnt;
    logic [N-1:0] exp_grant;
    modelPick(req, exp_empty, exp_lvl, exp_k);
    exp_grant = N'(1) << exp_k;
    i_valid   = 1'b1;
    i_request = req;
    @(negedge clk);
    i_valid   = 1'b0;
    i_request = N*P'($urandom);
    cnt = 0;
    while (!(o_grant_valid || o_empty) && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    if (!(o_grant_valid || o_empty)) begin
      checkOutput("response_timeout", 32'd0, 32'd1);
      applyReset();
      return;
    end
    if (exp_empty) begin
      checkOutput("empty_pulse", 32'(o_empty), 32'd1);
      checkOutput("empty_nogrant", 32'(o_grant_valid), 32'd0);
      @(negedge clk);
      checkOutput("empty_pulse_end", 32'(o_empty), 32'd0);
      checkOutput("empty_busy_low", 32'(o_busy), 32'd0);
      return;
    end
    checkOutput("grant", 32'(o_grant), 32'(exp_grant));
    checkOutput("grant_level", 32'(o_grant_level), 32'(exp_lvl));
    checkOutput("grant_busy", 32'(o_busy), 32'd1);
    if (knownGrant != '0) checkOutput("grant_known", 32'(o_grant), 32'(knownGrant));
    for (int h = 0; h < hold; h++) begin
      i_valid   = poke;
      i_request = N*P'($urandom);
      @(negedge clk);
      i_valid = 1'b0;
      checkOutput("hold_valid", 32'(o_grant_valid), 32'd1);
      checkOutput("hold_grant", 32'(o_grant), 32'(exp_grant));
      checkOutput("hold_level", 32'(o_grant_level), 32'(exp_lvl));
    end
    if (action == 3) begin
      applyReset();
      return;
    end
    i_accept = (action == 0 || action == 2);
    i_reject = (action == 1 || action == 2);
    @(negedge clk);
    i_accept = 1'b0;
    i_reject = 1'b0;
    checkIdleOutputs("release");
    if (action != 1) mptr[exp_lvl] = (exp_k + 1) % N;
  endtask

  // Directed scenarios, then randomized decisions
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_request = '0;
    i_accept  = 1'b0;
    i_reject  = 1'b0;
    for (int j = 0; j < P; j++) mptr[j] = 0;
    @(negedge clk);
    @(negedge clk);
    checkIdleOutputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b0001);
    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b0010);
    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b0100);
    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b1000);
    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b0001);

    applyStimulus(8'h21, 0, 0, 1'b0, 4'b0010);
    applyStimulus(8'h01, 0, 0, 1'b0, 4'b0001);

    applyStimulus(8'h06, 1, 0, 1'b0, 4'b0010);
    applyStimulus(8'h06, 0, 0, 1'b0, 4'b0010);
    applyStimulus(8'h06, 0, 0, 1'b0, 4'b0100);

    applyStimulus(8'h00, 0, 0, 1'b0, 4'b0000);
    applyStimulus(8'h0F, 2, 3, 1'b1, 4'b1000);
    applyStimulus(8'h0F, 0, 1, 1'b0, 4'b0001);

    applyStimulus(8'h0F, 3, 2, 1'b0, 4'b0010);
    applyStimulus(8'h0F, 0, 0, 1'b0, 4'b0001);

    for (int n = 0; n < 200; n++) begin
      logic [N*P-1:0] req;
      int act;
      req = N*P'($urandom);
      if ($urandom_range(0, 5) == 0) req = '0;
      else if ($urandom_range(0, 2) == 0) req[N*P-1 -: N] = '0;
      act = $urandom_range(0, 2);
      if ($urandom_range(0, 14) == 0) act = 3;
      applyStimulus(req, act, $urandom_range(0, 3), 1'($urandom_range(0, 1)), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
